// File: rtl/fsm_run_sequencer.sv
// rtl/fsm_run_sequencer.sv - batch job sequencer driving run/done core (optional watchdog: SEQ_TIMEOUT_EN)
module fsm_run_sequencer #(
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [CNT_WIDTH-1:0] i_num_jobs,
    output logic                 o_run,
    input  logic                 i_done,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_job_cnt,
    output logic                 o_all_done,
    output logic                 o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] job_cnt_q, job_cnt_d;
    logic [CNT_WIDTH-1:0] num_jobs_q, num_jobs_d;
    logic [CNT_WIDTH-1:0] cnt_inc;

    // Count after the job being acknowledged; compared before it is stored so it never wraps.
    assign cnt_inc = job_cnt_q + CNT_WIDTH'(1);

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_q, timeout_d;

    // Watchdog counter and sticky abort flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    // No watchdog in this build; the comparison is constant false and keeps the port tied low.
    assign o_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // State, progress counter and captured batch size.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            job_cnt_q  <= '0;
            num_jobs_q <= '0;
        end else begin
            state_q    <= state_d;
            job_cnt_q  <= job_cnt_d;
            num_jobs_q <= num_jobs_d;
        end
    end

    // Next-state logic: one run pulse per job, then wait for the core to acknowledge it.
    always_comb begin
        state_d    = state_q;
        job_cnt_d  = job_cnt_q;
        num_jobs_d = num_jobs_q;
`ifdef SEQ_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    num_jobs_d = i_num_jobs;
                    job_cnt_d  = '0;
`ifdef SEQ_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                    state_d    = (i_num_jobs == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
`ifdef SEQ_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_done) begin
                    job_cnt_d = cnt_inc;
                    state_d   = (cnt_inc == num_jobs_q) ? S_DONE : S_RUN;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_run      = (state_q == S_RUN);
    assign o_busy     = (state_q != S_IDLE);
    assign o_all_done = (state_q == S_DONE);
    assign o_job_cnt  = job_cnt_q;

endmodule

// File: tb/tb_fsm_run_sequencer.sv
// tb/tb_fsm_run_sequencer.sv - randomized self-checking bench for fsm_run_sequencer
module tb_fsm_run_sequencer;

    localparam int CW = 8;

    logic          clk;
    logic          reset;
    logic          i_start;
    logic [CW-1:0] i_num_jobs;
    logic          o_run;
    logic          i_done;
    logic          o_busy;
    logic [CW-1:0] o_job_cnt;
    logic          o_all_done;
    logic          o_timeout;

    int checks = 0;
    int errors = 0;
    int runs_seen = 0;
    int done_seen = 0;
    int exp_runs = 0;
    int exp_done = 0;
    int last_cnt = 0;
    bit prev_run = 1'b0;

    fsm_run_sequencer #(.CNT_WIDTH(CW), .TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_num_jobs (i_num_jobs),
        .o_run      (o_run),
        .i_done     (i_done),
        .o_busy     (o_busy),
        .o_job_cnt  (o_job_cnt),
        .o_all_done (o_all_done),
        .o_timeout  (o_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse monitor: counts run and batch-complete pulses, and flags a run held for two cycles.
    always @(negedge clk) begin
        if (!reset) begin
            if (o_run) begin
                runs_seen++;
                checks++;
                if (prev_run) begin
                    errors++;
                    $display("FAIL run_single_cycle: o_run high on two consecutive cycles at %0t, required one", $time);
                end
            end
            if (o_all_done) done_seen++;
            prev_run = o_run;
        end else begin
            prev_run = 1'b0;
        end
    end

    task automatic check_reset_outputs(input string name);
        checks++;
        if (o_run !== 1'b0 || o_busy !== 1'b0 || o_job_cnt !== '0 || o_all_done !== 1'b0 || o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s: run=%b busy=%b cnt=%0d all_done=%b timeout=%b, required all 0",
                     name, o_run, o_busy, o_job_cnt, o_all_done, o_timeout);
        end
    endtask

    // A batch of n jobs; the model core answers each run after a random number of idle WAIT cycles.
    task automatic run_batch(input int n, input int lo, input int hi, input bit hold_start, input bit spur_run);
        int lat;
        i_start    = 1'b1;
        i_num_jobs = n[CW-1:0];
        @(negedge clk);
        if (!hold_start) i_start = 1'b0;
        exp_runs += n;
        exp_done += 1;
        for (int j = 0; j < n; j++) begin
            checks++;
            if (o_run !== 1'b1 || o_job_cnt !== CW'(j)) begin
                errors++;
                $display("FAIL run_issue: o_run=%b cnt=%0d, required o_run=1 cnt=%0d", o_run, o_job_cnt, j);
            end
            if (hold_start) i_num_jobs = CW'($urandom);
            if (spur_run) i_done = 1'b1;
            @(negedge clk);
            i_done = 1'b0;
            checks++;
            if (o_run !== 1'b0 || o_busy !== 1'b1 || o_job_cnt !== CW'(j) || o_timeout !== 1'b0) begin
                errors++;
                $display("FAIL wait_entry: o_run=%b busy=%b cnt=%0d timeout=%b, required 0/1/%0d/0",
                         o_run, o_busy, o_job_cnt, o_timeout, j);
            end
            lat = int'($urandom_range(hi, lo));
            repeat (lat) @(negedge clk);
            i_done = 1'b1;
            @(negedge clk);
            i_done = 1'b0;
            checks++;
            if (o_job_cnt !== CW'(j + 1)) begin
                errors++;
                $display("FAIL cnt_step: cnt=%0d, required %0d", o_job_cnt, j + 1);
            end
        end
        checks++;
        if (o_all_done !== 1'b1 || o_run !== 1'b0 || o_busy !== 1'b1 || o_job_cnt !== CW'(n)) begin
            errors++;
            $display("FAIL batch_end: all_done=%b run=%b busy=%b cnt=%0d, required 1/0/1/%0d",
                     o_all_done, o_run, o_busy, o_job_cnt, n);
        end
        @(negedge clk);
        checks++;
        if (o_all_done !== 1'b0 || o_busy !== 1'b0 || o_job_cnt !== CW'(n)) begin
            errors++;
            $display("FAIL idle_after: all_done=%b busy=%b cnt=%0d, required 0/0/%0d",
                     o_all_done, o_busy, o_job_cnt, n);
        end
        last_cnt = n;
    endtask

    task automatic test_reset;
        i_start    = 1'b1;
        i_num_jobs = 8'd3;
        @(negedge clk);
        i_start = 1'b0;
        exp_runs += 1;
        #2 reset = 1'b1;
        #1 check_reset_outputs("reset_async_in_run");
        #9 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_release_idle");
        last_cnt = 0;
    endtask

    task automatic test_batch_of_three;
        run_batch(3, 2, 2, 1'b0, 1'b0);
    endtask

    task automatic test_zero_jobs;
        run_batch(0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random_batches;
        repeat (8) run_batch(int'($urandom_range(6, 1)), 0, 4, 1'b0, 1'($urandom_range(1, 0)));
    endtask

    task automatic test_max_batch;
        run_batch((1 << CW) - 1, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_spurious_idle;
        i_done = 1'b1;
        repeat (3) @(negedge clk);
        i_done = 1'b0;
        checks++;
        if (o_job_cnt !== CW'(last_cnt) || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle: cnt=%0d busy=%b, required %0d/0", o_job_cnt, o_busy, last_cnt);
        end
    endtask

    task automatic test_start_held;
        run_batch(2, 0, 3, 1'b1, 1'b0);
        i_num_jobs = 8'd1;
        @(negedge clk);
        i_start = 1'b0;
        exp_runs += 1;
        exp_done += 1;
        checks++;
        if (o_run !== 1'b1 || o_job_cnt !== '0) begin
            errors++;
            $display("FAIL start_held_restart: run=%b cnt=%0d, required 1/0", o_run, o_job_cnt);
        end
        @(negedge clk);
        i_done = 1'b1;
        @(negedge clk);
        i_done = 1'b0;
        checks++;
        if (o_all_done !== 1'b1 || o_job_cnt !== 8'd1) begin
            errors++;
            $display("FAIL start_held_second: all_done=%b cnt=%0d, required 1/1", o_all_done, o_job_cnt);
        end
        @(negedge clk);
        last_cnt = 1;
    endtask

    task automatic test_reset_mid_wait;
        i_start    = 1'b1;
        i_num_jobs = 8'd4;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        i_done = 1'b1;
        @(negedge clk);
        i_done = 1'b0;
        @(negedge clk);
        repeat (2) @(negedge clk);
        exp_runs += 2;
        checks++;
        if (o_job_cnt !== 8'd1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: cnt=%0d busy=%b, required 1/1", o_job_cnt, o_busy);
        end
        #2 reset = 1'b1;
        #1 check_reset_outputs("reset_async_in_wait");
        #9 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort_idle");
        run_batch(4, 0, 3, 1'b0, 1'b0);
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout;
        i_start    = 1'b1;
        i_num_jobs = 8'd2;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (o_all_done !== 1'b0 || o_busy !== 1'b1 || o_timeout !== 1'b0) begin
                errors++;
                $display("FAIL tmo_wait%0d: all_done=%b busy=%b timeout=%b, required 0/1/0", c, o_all_done, o_busy, o_timeout);
            end
            @(negedge clk);
        end
        exp_runs += 1;
        exp_done += 1;
        checks++;
        if (o_all_done !== 1'b1 || o_timeout !== 1'b1 || o_job_cnt !== '0) begin
            errors++;
            $display("FAIL tmo_abort: all_done=%b timeout=%b cnt=%0d, required 1/1/0", o_all_done, o_timeout, o_job_cnt);
        end
        @(negedge clk);
        checks++;
        if (o_timeout !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_sticky: timeout=%b busy=%b, required 1/0", o_timeout, o_busy);
        end
        run_batch(1, 7, 7, 1'b0, 1'b0);
    endtask
`else
    task automatic test_timeout;
        i_start    = 1'b1;
        i_num_jobs = 8'd1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (80) @(negedge clk);
        checks++;
        if (o_busy !== 1'b1 || o_all_done !== 1'b0 || o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL no_tmo_wait: busy=%b all_done=%b timeout=%b, required 1/0/0", o_busy, o_all_done, o_timeout);
        end
        i_done = 1'b1;
        @(negedge clk);
        i_done = 1'b0;
        exp_runs += 1;
        exp_done += 1;
        checks++;
        if (o_all_done !== 1'b1 || o_job_cnt !== 8'd1) begin
            errors++;
            $display("FAIL no_tmo_done: all_done=%b cnt=%0d, required 1/1", o_all_done, o_job_cnt);
        end
        @(negedge clk);
        last_cnt = 1;
    endtask
`endif

    initial begin
        reset      = 1'b1;
        i_start    = 1'b0;
        i_done     = 1'b0;
        i_num_jobs = '0;
        #3 check_reset_outputs("power_on_reset");
        #9 reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_batch_of_three();
        test_spurious_idle();
        test_zero_jobs();
        test_random_batches();
        test_start_held();
        test_spurious_idle();
        test_reset_mid_wait();
        test_timeout();
        test_max_batch();
        repeat (2) @(negedge clk);
        checks++;
        if (runs_seen !== exp_runs) begin
            errors++;
            $display("FAIL run_total: saw %0d run pulses, required %0d", runs_seen, exp_runs);
        end
        checks++;
        if (done_seen !== exp_done) begin
            errors++;
            $display("FAIL all_done_total: saw %0d completion pulses, required %0d", done_seen, exp_done);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
